// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: scan state
// encoding, blanking codes and the active-low hex-to-segment lookup.
package seg_scan_ctrl_pkg;

    // Segments are ordered {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Common-anode display: a 0 on an anode selects that digit.
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Standard hexadecimal glyphs, lower-case b and d so they differ from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: the display word and its
// load strobe, per-digit controls, and the pins toward the display.
interface seg_scan_ctrl_if;
    logic [31:0] data_in;
    logic        load;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        lzs;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    // Register/CPU side: supplies the value and controls, watches the pins.
    modport master (
        output data_in, load, dp_in, digit_en, lzs,
        input  an, seg, dp, frame_done
    );

    // Controller side.
    modport slave (
        input  data_in, load, dp_in, digit_en, lzs,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl_hexdec.sv
// Existing 4-bit hex to seven-segment decoder (combinational, active-low).
module seg_scan_ctrl_hexdec
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; the caller registers the result.
    always_comb begin
        seg_o = hex_to_seg(nib_i);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Each digit slot opens with a blanking gap, then drives one nibble of the
// shown word. New words are staged in a pending register and promoted only
// at the frame boundary so a frame never mixes two values.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             fd_q, fd_d;

    logic             slot_end;
    logic             frame_end;
    logic [31:0]      shown_shift;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic             dark;

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next scan position and blank/drive transitions.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        state_d   = state_q;
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        case (state_q)
            ST_BLANK: if (cnt_q == CNT_BLANK_END) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_end)               state_d = ST_BLANK;
            default:                              state_d = ST_BLANK;
        endcase
    end

    // Pending/shown handoff: a load on the boundary edge bypasses pending.
    always_comb begin
        shown_d    = shown_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (bus.load) pend_d = bus.data_in;
        if (frame_end) begin
            if (bus.load) begin
                shown_d    = bus.data_in;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                shown_d    = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (bus.load) begin
            pend_vld_d = 1'b1;
        end
    end

    // Output values are derived from the next scan position so that anode,
    // segment and frame_done registers all line up with the counter.
    assign shown_shift = shown_d >> {idx_d, 2'b00};
    assign nib         = shown_shift[3:0];

    seg_scan_ctrl_hexdec u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // Pin values for the upcoming cycle; dark digits keep the pins idle.
    always_comb begin
        an_d = ANODE_OFF;
        seg_d = SEG_BLANK;
        dp_d = 1'b1;
        dark = !bus.digit_en[idx_d] ||
               (bus.lzs && (idx_d != '0) && (shown_shift == 32'h0));
        if ((state_d == ST_DRIVE) && !dark) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = dec_seg;
            dp_d  = ~bus.dp_in[idx_d];
        end
        fd_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    // Display word storage and registered pin drivers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shown_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= ANODE_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            shown_q    <= shown_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SLOT_CYCLES=4, BLANK_CYCLES=1.
// cyc counts clock edges since reset release; one frame is 32 edges.
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   nvec;
    int   nmis;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(
        .NUM_DIGITS   (8),
        .SLOT_CYCLES  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-derived expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pins(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input logic fd_e);
        check({tag, ".an"},  32'(bus.an),         32'(an_e));
        check({tag, ".seg"}, 32'(bus.seg),        32'(seg_e));
        check({tag, ".dp"},  32'(bus.dp),         32'(dp_e));
        check({tag, ".fd"},  32'(bus.frame_done), 32'(fd_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pos, slot, ph;
        logic [7:0] an_e;
        logic [6:0] seg_e;
        nvec = 0;
        nmis = 0;
        cyc  = 0;
        rst_n        = 1'b0;
        bus.data_in  = 32'h0;
        bus.load     = 1'b0;
        bus.dp_in    = 8'h00;
        bus.digit_en = 8'hFF;
        bus.lzs      = 1'b0;

        // Reset held for five edges.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            pins("rst", 8'hFF, 7'h7F, 1'b1, 1'b0);
        end
        rst_n = 1'b1;
        cyc   = 0;
        pins("blank0", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(1);  pins("d0a", 8'hFE, 7'b0000001, 1'b1, 1'b0);
        run_to(3);  pins("d0c", 8'hFE, 7'b0000001, 1'b1, 1'b0);
        run_to(4);  pins("blank1", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(5);  check("d1.an", 32'(bus.an), 32'hFD);

        // Mid-frame load stays pending until the frame ends.
        run_to(10);
        bus.data_in = 32'h1234_5678;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        run_to(13); pins("d3old", 8'hF7, 7'b0000001, 1'b1, 1'b0);
        run_to(30); check("fd30", 32'(bus.frame_done), 32'h0);
        run_to(31); pins("d7end", 8'h7F, 7'b0000001, 1'b1, 1'b1);
        run_to(32); pins("f2blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(33); pins("f2d0", 8'hFE, 7'b0000000, 1'b1, 1'b0);
        run_to(41); pins("f2d2", 8'hFB, 7'b0100000, 1'b1, 1'b0);
        run_to(61); pins("f2d7", 8'h7F, 7'b1001111, 1'b1, 1'b0);

        // Digit enable mask with an all-F word.
        run_to(62);
        bus.data_in = 32'hFFFF_FFFF;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        check("fd63", 32'(bus.frame_done), 32'h1);
        bus.digit_en = 8'h0F;
        for (int k = 64; k <= 95; k++) begin
            run_to(k);
            pos  = k - 64;
            slot = pos / 4;
            ph   = pos % 4;
            if (ph == 0 || slot >= 4) begin
                an_e  = 8'hFF;
                seg_e = 7'h7F;
            end else begin
                an_e  = ~(8'b1 << slot);
                seg_e = 7'b0111000;
            end
            check("mask.an",  32'(bus.an),         32'(an_e));
            check("mask.seg", 32'(bus.seg),        32'(seg_e));
            check("mask.fd",  32'(bus.frame_done), (pos == 31) ? 32'h1 : 32'h0);
            bus.load = 1'b0;
            if (k == 94) begin
                bus.data_in = 32'h0000_00A5;
                bus.load    = 1'b1;
            end
            if (k == 95) begin
                bus.digit_en = 8'hFF;
                bus.lzs      = 1'b1;
            end
        end

        // Leading-zero suppression.
        run_to(97);  pins("lz0", 8'hFE, 7'b0100100, 1'b1, 1'b0);
        run_to(101); pins("lz1", 8'hFD, 7'b0001000, 1'b1, 1'b0);
        run_to(105); pins("lz2", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(125); pins("lz7", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(126);
        bus.data_in = 32'h0;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        run_to(129); pins("lzz0", 8'hFE, 7'b0000001, 1'b1, 1'b0);
        run_to(133); pins("lzz1", 8'hFF, 7'h7F, 1'b1, 1'b0);

        // Load exactly on the frame_done cycle goes straight to shown.
        run_to(159);
        check("fd159", 32'(bus.frame_done), 32'h1);
        bus.lzs     = 1'b0;
        bus.data_in = 32'hCAFE_0000;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        run_to(161); pins("cf0", 8'hFE, 7'b0000001, 1'b1, 1'b0);
        run_to(165);
        bus.data_in = 32'h1111_1111;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        run_to(170);
        bus.data_in = 32'h2222_2222;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
        run_to(177); pins("cf4", 8'hEF, 7'b0110000, 1'b1, 1'b0);
        run_to(189); pins("cf7", 8'h7F, 7'b0110001, 1'b1, 1'b0);
        run_to(193); pins("two0", 8'hFE, 7'b0010010, 1'b1, 1'b0);
        run_to(221); pins("two7", 8'h7F, 7'b0010010, 1'b1, 1'b0);

        // Decimal point on digit 0, then reset in the middle of slot 3.
        run_to(223);
        bus.dp_in = 8'h01;
        run_to(224); pins("dpb", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(225); pins("dp0a", 8'hFE, 7'b0010010, 1'b0, 1'b0);
        run_to(227); check("dp0c", 32'(bus.dp), 32'h0);
        run_to(228); pins("dpb1", 8'hFF, 7'h7F, 1'b1, 1'b0);
        run_to(229); pins("dp1", 8'hFD, 7'b0010010, 1'b1, 1'b0);
        run_to(237); pins("s3", 8'hF7, 7'b0010010, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        pins("midrst", 8'hFF, 7'h7F, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        pins("midrst2", 8'hFF, 7'h7F, 1'b1, 1'b0);
        step();
        pins("restart", 8'hFE, 7'b0000001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
